// File: rtl/pixel_stream_source.sv
// pixel_stream_source: walks a WIDTH x HEIGHT frame interleaved across
// NUM_SOLVERS result memories and issues reads with READ_LATENCY. The
// returned data is colour-mapped to RGB565 and queued in a credit-controlled
// show-ahead FIFO that feeds an Avalon-ST video sink.
// Ports:
//   clock, reset_n           single clock, async active-low reset
//   enable, color_mode       frame start / palette (latched at frame start)
//   rd_en, rd_solver_id,
//   rd_addr, rd_data         solver memory read port
//   stream_*                 Avalon-ST source (ready/valid, sop/eop, RGB565)
//   busy, frame_done,
//   frame_count              status

package pixel_stream_source_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } pix_t;
endpackage

module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int unsigned NUM_SOLVERS  = 29,
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ID_W         = 6,
  parameter int unsigned ADDR_W       = 19
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        color_mode,
  output logic              rd_en,
  output logic [ID_W-1:0]   rd_solver_id,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              stream_ready,
  output logic              stream_valid,
  output logic              stream_startofpacket,
  output logic              stream_endofpacket,
  output logic [15:0]       stream_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int unsigned NUM_PIX = WIDTH * HEIGHT;
  localparam int unsigned PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned REP     = 6 / DATA_W + 1;
  localparam int unsigned REP_W   = REP * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    start_c, issue_c, done_c;
  logic [ID_W-1:0]         id_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [PIX_W-1:0]        pix_q;
  logic [1:0]              mode_q;
  logic [OCC_W-1:0]        occ_q;
  logic [READ_LATENCY-1:0] sb_vld, sb_sop, sb_eop;
  pix_t                    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [OCC_W-1:0]        fifo_cnt;
  logic                    last_c, pop_c, wr_c, empty_c;
  pix_t                    head_c, wr_entry_c;

  // RGB565 colour map; fields are filled MSB-first by repeating the value bits
  function automatic logic [15:0] colour_map(input logic [DATA_W-1:0] d,
                                             input logic [1:0] mode);
    logic [DATA_W-1:0] v;
    logic [REP_W-1:0]  rep;
    logic [4:0]        r5;
    logic [5:0]        g6;
    logic [5:0]        g_only;
    v      = (mode == 2'd2) ? ~d : d;
    rep    = {REP{v}};
    r5     = 5'(rep >> (REP_W - 5));
    g6     = 6'(rep >> (REP_W - 6));
    g_only = 6'({v, 6'b0} >> DATA_W);
    case (mode)
      2'd0:    colour_map = {5'b0, g_only, 5'b0};
      2'd3:    colour_map = (&d) ? 16'h0000 : {r5, g6, r5};
      default: colour_map = {r5, g6, r5};
    endcase
  endfunction

  assign last_c  = (pix_q == PIX_W'(NUM_PIX - 1));
  assign empty_c = (fifo_cnt == '0);
  assign head_c  = fifo_mem[rd_ptr];
  assign pop_c   = !empty_c && stream_ready;
  assign wr_c    = sb_vld[READ_LATENCY-1];

  // Frame sequencing; reads issue only while a credit is free
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    issue_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          start_c = 1'b1;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        issue_c = (occ_q < OCC_W'(FIFO_DEPTH));
        if (issue_c && last_c) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop_c && head_c.eop) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Pixel walk: id cycles through the solvers, addr steps when id wraps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q   <= '0;
      addr_q <= '0;
      pix_q  <= '0;
      mode_q <= '0;
    end else if (start_c) begin
      id_q   <= '0;
      addr_q <= '0;
      pix_q  <= '0;
      mode_q <= color_mode;
    end else if (issue_c) begin
      pix_q <= pix_q + PIX_W'(1);
      if (id_q == ID_W'(NUM_SOLVERS - 1)) begin
        id_q   <= '0;
        addr_q <= addr_q + ADDR_W'(1);
      end else begin
        id_q <= id_q + ID_W'(1);
      end
    end
  end

  // Credits cover both in-flight reads and FIFO entries
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) occ_q <= '0;
    else if (issue_c && !pop_c) occ_q <= occ_q + OCC_W'(1);
    else if (!issue_c && pop_c) occ_q <= occ_q - OCC_W'(1);
  end

  // Sideband flags ride alongside each read for READ_LATENCY cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_vld <= '0;
      sb_sop <= '0;
      sb_eop <= '0;
    end else begin
      sb_vld <= READ_LATENCY'({sb_vld, issue_c});
      sb_sop <= READ_LATENCY'({sb_sop, issue_c && (pix_q == '0)});
      sb_eop <= READ_LATENCY'({sb_eop, issue_c && last_c});
    end
  end

  assign wr_entry_c = '{data: colour_map(rd_data, mode_q),
                        sop:  sb_sop[READ_LATENCY-1],
                        eop:  sb_eop[READ_LATENCY-1]};

  // Show-ahead FIFO; credits guarantee it never overflows
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_c)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_c && !pop_c)      fifo_cnt <= fifo_cnt + OCC_W'(1);
      else if (!wr_c && pop_c) fifo_cnt <= fifo_cnt - OCC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_c) fifo_mem[wr_ptr] <= wr_entry_c;
  end

  // Frame completion status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= done_c;
      if (done_c) frame_count <= frame_count + 16'd1;
    end
  end

  assign rd_en                = issue_c;
  assign rd_solver_id         = issue_c ? id_q : '0;
  assign rd_addr              = issue_c ? addr_q : '0;
  assign stream_valid         = !empty_c;
  assign stream_data          = empty_c ? 16'h0000 : head_c.data;
  assign stream_startofpacket = !empty_c && head_c.sop;
  assign stream_endofpacket   = !empty_c && head_c.eop;
  assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source on a 4x3 frame over 5 solvers.
// The memory model returns d = p mod 16 (or 0xF when forced) two cycles
// after each read.
module tb_pixel_stream_source;

  localparam int NS = 5, NPIX = 12, FD = 4;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [1:0]  color_mode;
  logic        rd_en;
  logic [5:0]  rd_solver_id;
  logic [18:0] rd_addr;
  logic [3:0]  rd_data;
  logic        stream_ready;
  logic        stream_valid;
  logic        stream_startofpacket;
  logic        stream_endofpacket;
  logic [15:0] stream_data;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  pixel_stream_source #(
    .NUM_SOLVERS(5), .WIDTH(4), .HEIGHT(3), .DATA_W(4), .READ_LATENCY(2),
    .FIFO_DEPTH(4), .ID_W(6), .ADDR_W(19)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .color_mode(color_mode),
    .rd_en(rd_en), .rd_solver_id(rd_solver_id), .rd_addr(rd_addr), .rd_data(rd_data),
    .stream_ready(stream_ready), .stream_valid(stream_valid),
    .stream_startofpacket(stream_startofpacket), .stream_endofpacket(stream_endofpacket),
    .stream_data(stream_data), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand-specialised 4-bit palette
  function automatic logic [15:0] exp_colour(input logic [3:0] d, input logic [1:0] m);
    logic [3:0] v;
    v = (m == 2'd2) ? ~d : d;
    if (m == 2'd0) return {5'b0, d, 2'b00, 5'b0};
    if (m == 2'd3 && d == 4'hF) return 16'h0000;
    return {v, v[3], v, v[3:2], v, v[3]};
  endfunction

  // Memory model: two-cycle read latency
  int   m1_p = 0, m2_p = 0;
  logic mem_all_f = 1'b0;
  always @(posedge clock) begin
    m1_p <= int'(rd_addr) * NS + int'(rd_solver_id);
    m2_p <= m1_p;
  end
  assign rd_data = mem_all_f ? 4'hF : 4'(m2_p);

  // Monitor: record reads and accepted beats, check head hold during stalls
  int          cyc = 0;
  logic [17:0] beat_q[$];
  int          beat_cyc[$];
  logic [24:0] rd_q[$];
  int          rd_cyc[$];
  int          n_done = 0;
  int          occ_max = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (stream_valid && stream_ready) begin
      beat_q.push_back({stream_startofpacket, stream_endofpacket, stream_data});
      beat_cyc.push_back(cyc);
    end
    if (rd_en) begin
      rd_q.push_back({rd_solver_id, rd_addr});
      rd_cyc.push_back(cyc);
    end
    if (frame_done) n_done++;
    if (int'(dut.occ_q) > occ_max) occ_max = int'(dut.occ_q);
    if (prev_stall) chk("head_hold", 32'({stream_valid, stream_data}), 32'({1'b1, prev_data}));
    prev_stall = stream_valid && !stream_ready && reset_n;
    prev_data  = stream_data;
  end

  int exp_fc = 0;

  task automatic run_frame(input string tag, input logic [1:0] mode, input logic [1:0] mode_late,
                           input bit stall, input bit drop, input bit all_f,
                           input bit chk10, input logic [15:0] exp10);
    int bb, br, bd, e, resume, guard, first_post;
    bit stalled;
    logic [3:0] d;
    bb = beat_q.size(); br = rd_q.size(); bd = n_done;
    stalled = 0; resume = 0; guard = 0;
    mem_all_f = all_f;
    @(posedge clock); #1;
    color_mode = mode; enable = 1'b1; e = cyc;
    while (n_done == bd && guard < 300) begin
      @(posedge clock); #1;
      guard++;
      if (rd_q.size() - br >= 5) color_mode = mode_late;
      if (drop && rd_q.size() - br >= 3) enable = 1'b0;
      if (beat_q.size() - bb >= NPIX) enable = 1'b0;
      if (stall && !stalled && beat_q.size() - bb >= 3) begin
        stream_ready = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        chk({tag, "_stall_occ"}, 32'(dut.occ_q), 32'(FD));
        chk({tag, "_stall_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_stall_valid"}, 32'(stream_valid), 32'd1);
        @(posedge clock); #1;
        stream_ready = 1'b1; resume = cyc; stalled = 1;
      end
    end
    chk({tag, "_no_timeout"}, 32'(guard < 300), 32'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    exp_fc++;
    chk({tag, "_done_pulses"}, 32'(n_done - bd), 32'd1);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_n_reads"}, 32'(rd_q.size() - br), 32'(NPIX));
    chk({tag, "_n_beats"}, 32'(beat_q.size() - bb), 32'(NPIX));
    if (rd_q.size() - br == NPIX && beat_q.size() - bb == NPIX) begin
      chk({tag, "_first_rd_lat"}, 32'(rd_cyc[br] - e), 32'd1);
      chk({tag, "_first_beat_lat"}, 32'(beat_cyc[bb] - e), 32'd4);
      for (int i = 0; i < NPIX; i++) begin
        d = all_f ? 4'hF : 4'(i);
        chk({tag, "_rd", $sformatf("%0d", i)}, 32'(rd_q[br + i]), 32'({6'(i % NS), 19'(i / NS)}));
        chk({tag, "_beat", $sformatf("%0d", i)}, 32'(beat_q[bb + i]),
            32'({i == 0, i == NPIX - 1, exp_colour(d, mode)}));
      end
      if (chk10) chk({tag, "_pix10"}, 32'(beat_q[bb + 10][15:0]), 32'(exp10));
      if (!stall) begin
        chk({tag, "_rd_span"}, 32'(rd_cyc[br + NPIX - 1] - rd_cyc[br]), 32'(NPIX - 1));
        chk({tag, "_beat_span"}, 32'(beat_cyc[bb + NPIX - 1] - beat_cyc[bb]), 32'(NPIX - 1));
      end else begin
        first_post = bb + NPIX - 1;
        for (int i = NPIX - 1; i >= 0; i--)
          if (beat_cyc[bb + i] >= resume) first_post = bb + i;
        chk({tag, "_resume_lat"}, 32'(beat_cyc[first_post] - resume), 32'd0);
        chk({tag, "_resume_span"}, 32'(beat_cyc[bb + NPIX - 1] - beat_cyc[first_post]),
            32'(bb + NPIX - 1 - first_post));
      end
    end
  endtask

  initial begin
    int br, guard;
    reset_n = 1'b0; enable = 1'b0; color_mode = 2'd0; stream_ready = 1'b1;
    #1;
    chk("reset_rd", 32'({rd_en, rd_solver_id, rd_addr}), 32'd0);
    chk("reset_stream", 32'({stream_valid, stream_startofpacket, stream_endofpacket, stream_data}), 32'd0);
    chk("reset_status", 32'({busy, frame_done, frame_count}), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    run_frame("full_m1",  2'd1, 2'd1, 0, 0, 0, 1, 16'hAD55);
    run_frame("midmode",  2'd0, 2'd1, 0, 0, 0, 1, 16'h0500);
    run_frame("stall_m1", 2'd1, 2'd1, 1, 0, 0, 1, 16'hAD55);
    run_frame("mode2",    2'd2, 2'd2, 0, 0, 0, 1, 16'h52AA);
    run_frame("mode3_f",  2'd3, 2'd3, 0, 0, 1, 1, 16'h0000);
    run_frame("en_drop",  2'd1, 2'd1, 0, 1, 0, 0, 16'h0000);

    // Reset in the middle of a frame
    br = rd_q.size(); guard = 0; mem_all_f = 1'b0;
    @(posedge clock); #1;
    color_mode = 2'd1; enable = 1'b1;
    while (rd_q.size() - br < 6 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("rst_mid_reached", 32'(guard < 100), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rd", 32'({rd_en, rd_solver_id, rd_addr}), 32'd0);
    chk("rst_mid_stream", 32'({stream_valid, stream_startofpacket, stream_endofpacket, stream_data}), 32'd0);
    chk("rst_mid_status", 32'({busy, frame_done, frame_count}), 32'd0);
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_fc = 0;
    @(negedge clock);
    chk("rst_rel_count", 32'(frame_count), 32'd0);
    chk("rst_rel_valid", 32'(stream_valid), 32'd0);
    run_frame("after_rst", 2'd1, 2'd1, 0, 0, 0, 1, 16'hAD55);

    chk("occ_max", 32'(occ_max), 32'(FD));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
